// File: rtl/xbar_input_requester.sv
// Crossbar input-port requester: buffers flits, requests the head packet's output, streams it while granted.
// Optional macro XBAR_REQ_TIMEOUT_EN adds a sticky req_timeout flag for long grant waits.
module xbar_input_requester #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int DEST_W = 4
`ifdef XBAR_REQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 255
`endif
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_sop,
   input  logic                   in_eop,
   output logic [2**DEST_W-1:0]   request,
   input  logic [2**DEST_W-1:0]   grant,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic [DEST_W-1:0]      out_port,
   output logic [7:0]             drop_cnt
`ifdef XBAR_REQ_TIMEOUT_EN
   ,
   output logic                   req_timeout
`endif
);

   localparam int N_OUT = 2**DEST_W;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;

   logic [DATA_W+1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr, r_rptr;
   logic [AW:0]       r_count;
   state_t            r_state, w_next;
   logic [DEST_W-1:0] r_dest;
   logic [7:0]        r_drop_cnt;

   logic              w_empty, w_push, w_pop, w_drop, w_latch, w_grant_hit;
   logic [DATA_W+1:0] w_head;

   assign w_empty     = (r_count == '0);
   assign in_ready    = (r_count != CNT_FULL);
   assign w_push      = in_valid & in_ready;
   assign w_head      = r_mem[r_rptr];
   assign w_grant_hit = grant[r_dest];

   assign out_data  = w_head[DATA_W-1:0];
   assign out_eop   = w_head[DATA_W];
   assign out_sop   = w_head[DATA_W+1];
   assign out_valid = (r_state == S_SEND) & w_grant_hit & ~w_empty;
   assign out_port  = r_dest;
   assign drop_cnt  = r_drop_cnt;
   assign request   = (r_state != S_IDLE) ? (N_OUT'(1) << r_dest) : '0;

   // Flit storage carries no reset; only pointers and occupancy do.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr] <= {in_sop, in_eop, in_data};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_dest     <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) r_dest <= w_head[DEST_W-1:0];
         if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_pop   = 1'b0;
      w_drop  = 1'b0;
      w_latch = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               // A head flit without sop cannot start a packet, so it is discarded.
               if (w_head[DATA_W+1]) begin
                  w_latch = 1'b1;
                  w_next  = S_REQ;
               end else begin
                  w_pop  = 1'b1;
                  w_drop = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (w_grant_hit) w_next = S_SEND;
         end
         S_SEND: begin
            if (out_valid && out_ready) begin
               w_pop = 1'b1;
               if (w_head[DATA_W]) w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

`ifdef XBAR_REQ_TIMEOUT_EN
   logic [7:0] r_to_cnt;
   logic       r_to_flag;

   assign req_timeout = r_to_flag;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
      end else if (r_state == S_REQ && !w_grant_hit) begin
         if (r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
         if (({1'b0, r_to_cnt} + 9'd1) >= 9'(TIMEOUT)) r_to_flag <= 1'b1;
      end else if (r_state != S_REQ) begin
         r_to_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_xbar_input_requester.sv
// Bench for xbar_input_requester: directed test-plan steps plus randomized traffic against a packet-level scoreboard.
module tb_xbar_input_requester;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int DEST_W = 4;
   localparam int N_OUT  = 16;
`ifdef XBAR_REQ_TIMEOUT_EN
   localparam int TMO = 10;
   logic req_timeout;
`endif

   logic              clock, reset;
   logic              in_valid, in_ready, in_sop, in_eop;
   logic [DATA_W-1:0] in_data;
   logic [N_OUT-1:0]  request, grant;
   logic              out_valid, out_ready, out_sop, out_eop;
   logic [DATA_W-1:0] out_data;
   logic [DEST_W-1:0] out_port;
   logic [7:0]        drop_cnt;

   xbar_input_requester #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .DEST_W(DEST_W)
`ifdef XBAR_REQ_TIMEOUT_EN
      , .TIMEOUT(TMO)
`endif
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop),
      .request(request), .grant(grant),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
      .drop_cnt(drop_cnt)
`ifdef XBAR_REQ_TIMEOUT_EN
      , .req_timeout(req_timeout)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: flits that should emerge, in order; orphan flits are counted as drops instead.
   logic [33:0] exp_q[$];
   logic [33:0] gen_q[$];
   bit          in_pkt, out_in_pkt;
   logic [3:0]  cur_dest;
   int          exp_drop;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic observe();
      logic [33:0] f;
      if (reset) begin
         exp_q.delete();
         in_pkt = 0; out_in_pkt = 0; exp_drop = 0;
         return;
      end
      if (out_valid) begin
         chk("ov_needs_grant", 64'(grant[out_port]), 64'd1);
         chk("ov_request", 64'(request), 64'(N_OUT'(1) << out_port));
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("out_unexpected_flit", 64'd1, 64'd0);
         end else begin
            f = exp_q.pop_front();
            chk("out_flit", 64'({out_sop, out_eop, out_data}), 64'(f));
            if (!out_in_pkt) cur_dest = f[3:0];
            chk("out_port", 64'(out_port), 64'(cur_dest));
            out_in_pkt = !f[32];
         end
      end
      if (in_valid && in_ready) begin
         f = {in_sop, in_eop, in_data};
         if (!in_pkt && !in_sop) begin
            if (exp_drop < 255) exp_drop++;
         end else begin
            exp_q.push_back(f);
            in_pkt = !in_eop;
         end
      end
   endtask

   task automatic neg();
      @(negedge clock);
   endtask

   task automatic adv();
      observe();
      @(posedge clock);
      #1;
   endtask

   task automatic cyc();
      neg();
      adv();
   endtask

   task automatic push(input logic [31:0] d, input logic s, input logic e);
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
      neg();
      chk("push_ready", 64'(in_ready), 64'd1);
      adv();
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          k, len, dst;
      bit          hs;
      bit          pat [6];

      in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0;
      grant = '0; out_ready = 0; reset = 1;
      in_pkt = 0; out_in_pkt = 0; exp_drop = 0; cur_dest = '0;
      @(posedge clock); #1;
      cyc(); cyc();
      reset = 0;

      // Reset state
      neg();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_request", 64'(request), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_port", 64'(out_port), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      adv();

      // Single-flit packet to output 5, grant tied high
      grant = 16'h0020; out_ready = 1;
      push(32'h0000_0005, 1, 1);
      neg(); chk("t1_req_early", 64'(request), 64'd0); adv();
      neg();
      chk("t1_request", 64'(request), 64'h0020);
      chk("t1_ov_in_req", 64'(out_valid), 64'd0);
      adv();
      neg();
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_port", 64'(out_port), 64'd5);
      chk("t1_out_data", 64'(out_data), 64'h5);
      adv();
      neg();
      chk("t1_req_cleared", 64'(request), 64'd0);
      chk("t1_ov_cleared", 64'(out_valid), 64'd0);
      adv();

      // 4-flit packet to output 3, grant arrives late
      grant = '0; out_ready = 1;
      for (int i = 0; i < 4; i++) push(32'h3000_0003 + 32'(i) * 32'h100, i == 0, i == 3);
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("t2_request", 64'(request), 64'h0008);
         chk("t2_no_ov", 64'(out_valid), 64'd0);
         adv();
      end
      grant = 16'h0008;
      neg(); chk("t2_ov_grant_cycle", 64'(out_valid), 64'd0); adv();
      for (int i = 0; i < 4; i++) begin
         neg();
         chk("t2_ov", 64'(out_valid), 64'd1);
         chk("t2_data", 64'(out_data), 64'(32'h3000_0003 + 32'(i) * 32'h100));
         chk("t2_eop", 64'(out_eop), 64'(i == 3));
         adv();
      end
      neg(); chk("t2_req_cleared", 64'(request), 64'd0); adv();

      // Same packet with grant withdrawn for two cycles mid-packet
      grant = 16'h0008; out_ready = 0;
      for (int i = 0; i < 4; i++) push(32'h4000_0003 + 32'(i) * 32'h100, i == 0, i == 3);
      out_ready = 1;
      pat = '{1, 1, 0, 0, 1, 1};
      k = 0;
      for (int i = 0; i < 6; i++) begin
         grant = pat[i] ? 16'h0008 : 16'h0000;
         neg();
         if (pat[i]) begin
            chk("t3_ov", 64'(out_valid), 64'd1);
            chk("t3_data", 64'(out_data), 64'(32'h4000_0003 + 32'(k) * 32'h100));
            k++;
         end else begin
            chk("t3_gap_ov", 64'(out_valid), 64'd0);
            chk("t3_gap_req", 64'(request), 64'h0008);
         end
         adv();
      end
      neg(); chk("t3_req_cleared", 64'(request), 64'd0); adv();

      // Fill the FIFO with out_ready low, then release one slot
      grant = '0; out_ready = 0;
      for (int i = 0; i < 8; i++) push(32'h5000_0007 + 32'(i) * 32'h100, i == 0, i == 7);
      neg();
      chk("t4_full_ready", 64'(in_ready), 64'd0);
      chk("t4_request", 64'(request), 64'h0080);
      adv();
      grant = 16'h0080;
      neg(); chk("t4_ov_grant_cycle", 64'(out_valid), 64'd0); adv();
      out_ready = 1;
      in_valid = 1; in_data = 32'h0000_0009; in_sop = 1; in_eop = 1;
      neg();
      chk("t4_ov", 64'(out_valid), 64'd1);
      chk("t4_ready_during_pop", 64'(in_ready), 64'd0);
      adv();
      out_ready = 0;
      neg(); chk("t4_ready_after_pop", 64'(in_ready), 64'd1); adv();
      in_valid = 0; in_sop = 0; in_eop = 0;
      grant = '1; out_ready = 1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
      neg();
      chk("t4_all_flits_out", 64'(exp_q.size()), 64'd0);
      chk("t4_req_cleared", 64'(request), 64'd0);
      adv();

      // Orphan flit while idle
      grant = '0; out_ready = 0;
      push(32'h0000_0044, 0, 1);
      for (int i = 0; i < 3; i++) begin
         neg(); chk("t5_request", 64'(request), 64'd0); adv();
      end
      neg();
      chk("t5_drop_cnt", 64'(drop_cnt), 64'd1);
      chk("t5_drop_model", 64'(drop_cnt), 64'(exp_drop));
      adv();

      // Randomized traffic with random grants and back-pressure
      for (int c = 0; c < 1500; c++) begin
         if (gen_q.size() == 0) begin
            if ($urandom_range(0, 7) == 0) begin
               gen_q.push_back({1'b0, 1'($urandom_range(0, 1)), 32'($urandom)});
            end else begin
               len = $urandom_range(1, 5);
               dst = $urandom_range(0, 15);
               for (int j = 0; j < len; j++) begin
                  d = $urandom;
                  if (j == 0) d[3:0] = 4'(dst);
                  gen_q.push_back({j == 0, j == len - 1, d});
               end
            end
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         {in_sop, in_eop, in_data} = gen_q[0];
         out_ready = ($urandom_range(0, 3) != 0);
         grant     = 16'($urandom);
         neg();
         hs = in_valid && in_ready;
         adv();
         if (hs) gen_q.delete(0);
      end
      grant = '1; out_ready = 1;
      for (int c = 0; c < 400 && (gen_q.size() != 0 || exp_q.size() != 0); c++) begin
         in_valid = (gen_q.size() != 0);
         if (gen_q.size() != 0) {in_sop, in_eop, in_data} = gen_q[0];
         neg();
         hs = in_valid && in_ready;
         adv();
         if (hs) gen_q.delete(0);
      end
      in_valid = 0; in_sop = 0; in_eop = 0;
      cyc(); cyc();
      neg();
      chk("rnd_all_flits_out", 64'(exp_q.size()), 64'd0);
      chk("rnd_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("rnd_request_idle", 64'(request), 64'd0);
      chk("rnd_ov_idle", 64'(out_valid), 64'd0);
      adv();

      // Reset while a packet waits for grant
      grant = '0; out_ready = 0;
      push(32'h0000_0009, 1, 1);
      neg();
`ifdef XBAR_REQ_TIMEOUT_EN
      chk("to_clear_start", 64'(req_timeout), 64'd0);
`endif
      adv();
      for (int i = 0; i < 5; i++) cyc();
      neg();
      chk("rm_request", 64'(request), 64'h0200);
`ifdef XBAR_REQ_TIMEOUT_EN
      chk("to_not_yet", 64'(req_timeout), 64'd0);
`endif
      adv();
      for (int i = 0; i < 8; i++) cyc();
      neg();
`ifdef XBAR_REQ_TIMEOUT_EN
      chk("to_set", 64'(req_timeout), 64'd1);
`endif
      chk("rm_request_held", 64'(request), 64'h0200);
      adv();
      reset = 1;
      cyc();
      reset = 0;
      neg();
      chk("rm_request_reset", 64'(request), 64'd0);
      chk("rm_ov_reset", 64'(out_valid), 64'd0);
      chk("rm_in_ready_reset", 64'(in_ready), 64'd1);
`ifdef XBAR_REQ_TIMEOUT_EN
      chk("to_cleared_reset", 64'(req_timeout), 64'd0);
`endif
      adv();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xbar_input_requester.md
Name: xbar_input_requester

Overview:
- Crossbar input-port front end; the requester side of the 16-way round-robin output arbiter's request/grant handshake.
- Buffers incoming packet flits in a FIFO and decodes the head flit's destination.
- Drives a one-hot request to the output arbiters, waits for the matching grant, then streams the packet to the crossbar datapath while the grant is held.
- One instance per crossbar input.

Parameters:
- DATA_W, 32: flit data width.
- DEPTH, 8: FIFO depth in flits, power of 2, at least 2.
- DEST_W, 4: destination field width; N_OUT = 2**DEST_W = 16 outputs.
- TIMEOUT, 255: request-wait limit in cycles. Used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream flit valid
- in_ready  out  1  FIFO can accept a flit
- in_data  in  DATA_W  flit payload; on the head flit, bits [DEST_W-1:0] are the destination
- in_sop  in  1  first flit of packet
- in_eop  in  1  last flit of packet (sop and eop together = single-flit packet)
- request  out  2**DEST_W  one-hot request to the output arbiters
- grant  in  2**DEST_W  grant vector from the arbiters; only bit [dest] is examined
- out_valid  out  1  flit presented to the crossbar
- out_ready  in  1  crossbar accepts the flit
- out_data  out  DATA_W  flit payload
- out_sop, out_eop  out  1 each  packet framing
- out_port  out  DEST_W  destination of the current packet
- drop_cnt  out  8  count of flits dropped for bad framing; saturates at 255

Behaviour:
- Reset values:
  - FIFO empty, state IDLE.
  - request = 0, out_valid = 0, out_port = 0, drop_cnt = 0.
  - in_ready = 1 in the first cycle after reset.
- FIFO:
  - Entry = {sop, eop, data}.
  - Push when in_valid & in_ready. in_ready = !full, registered count only; no pass-through.
  - When full, a same-cycle pop does not raise in_ready until the next cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- State machine {IDLE, REQ, SEND}:
  - IDLE, FIFO non-empty, head.sop = 1: latch dest = head.data[DEST_W-1:0] into out_port; go to REQ.
  - IDLE, head.sop = 0: pop and discard the flit; drop_cnt += 1 (saturating); stay in IDLE.
  - REQ: request = one-hot(dest), starting the cycle after entry. When grant[dest] = 1, go to SEND. Grant bits other than dest are ignored.
  - SEND: request held at one-hot(dest).
    - out_valid = grant[dest] & !empty.
    - Pop when out_valid & out_ready.
    - If grant[dest] drops mid-packet, out_valid = 0 and the packet stalls; request stays asserted.
  - SEND, popped flit has eop: request = 0 in the next cycle; return to IDLE. The next packet cannot request earlier than the cycle after IDLE.
- Framing errors:
  - A sop flit found in SEND before eop is forwarded unchanged; the current packet is not terminated.
- Outputs:
  - out_data, out_sop and out_eop are the FIFO head, combinational from registered storage.
  - They are valid only when out_valid = 1.
- Reset mid-packet:
  - FIFO is flushed and state returns to IDLE.
  - request = 0 the cycle after reset is sampled high.
  - Partial packets are lost.
- Latency:
  - Flit written at cycle t is a head candidate at t+1.
  - Earliest request is at t+2.
  - Earliest out_valid is on the first cycle grant[dest] is seen high in REQ, plus one.

Optional Feature:
- Macro: XBAR_REQ_TIMEOUT_EN.
- With the macro defined:
  - Adds output req_timeout (1 bit, sticky).
  - An 8-bit counter runs while the block is in REQ with grant[dest] = 0, and clears on leaving REQ.
  - When the counter reaches TIMEOUT, req_timeout = 1 until reset. Request is unaffected.
- Without the macro: no counter and no port. Behaviour is otherwise identical.

Test Plan:
- Single-flit packet, data 0x0000_0005, sop = eop = 1; grant[5] tied high. Required: request = 0x0020 two cycles after push; out_valid with out_port = 5 the next cycle; request = 0 after the pop.
- 4-flit packet to dest 3; grant[3] asserted 3 cycles after request. Required: no out_valid before grant; 4 consecutive flits with out_ready = 1; eop on the 4th flit.
- Same packet with grant[3] dropped after flit 2 for 2 cycles. Required: out_valid = 0 during the gap, request stays 0x0008, flits 3 and 4 follow in order.
- Fill the FIFO with 8 flits while out_ready = 0. Required: in_ready = 0 at count 8; one pop restores in_ready the next cycle; no flit lost or duplicated.
- Non-sop flit while IDLE. Required: discarded, drop_cnt = 1, request stays 0.
- With XBAR_REQ_TIMEOUT_EN and TIMEOUT = 10, grant held low. Required: req_timeout = 1 after 10 REQ cycles, stays 1; reset clears it along with request and out_valid.
